// File: rtl/note_player.sv
// note_player: buffers {half-period, duration} note commands in a small FIFO
// and plays them back-to-back as a square wave on the speaker pin.
// A half-period of 0 plays a rest, and a duration of 0 skips the note.
//
// state | meaning
// IDLE  | nothing to play, waiting for the FIFO to become non-empty
// LOAD  | one cycle: pop head note, clear counters, speaker low
// PLAY  | tone counter toggles speaker, ms prescaler times the note
module note_player #(
    parameter int TICK_DIV   = 50000,
    parameter int FIFO_DEPTH = 4,
    parameter int PERIOD_W   = 20,
    parameter int DUR_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                note_valid,
    output logic                note_ready,
    input  logic [PERIOD_W-1:0] note_half_period,
    input  logic [DUR_W-1:0]    note_dur_ms,
    output logic                speaker,
    output logic                busy,
    output logic                note_done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [PERIOD_W-1:0] r_fifo_hp  [FIFO_DEPTH];
    logic [DUR_W-1:0]    r_fifo_dur [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic [PERIOD_W-1:0] r_hp;
    logic [PERIOD_W-1:0] r_tone;
    logic [DUR_W-1:0]    r_dur;
    logic [DUR_W-1:0]    r_ms;
    logic [PRE_W-1:0]    r_pre;
    logic                r_speaker;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_done;
    logic [PERIOD_W-1:0] w_head_hp;
    logic [DUR_W-1:0]    w_head_dur;
    logic                w_tick;
    logic                w_end;
    logic                w_tone_wrap;

    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = note_valid && !w_full;
    assign w_head_hp   = r_fifo_hp[r_rd_ptr];
    assign w_head_dur  = r_fifo_dur[r_rd_ptr];
    assign w_tick      = (r_pre == PRE_W'(TICK_DIV - 1));
    // Duration compares against the captured value, so the ms counter never wraps.
    assign w_end       = (r_state == S_PLAY) && w_tick && (r_ms == (r_dur - DUR_W'(1)));
    assign w_tone_wrap = (r_hp != '0) && (r_tone == (r_hp - PERIOD_W'(1)));

    // FIFO storage: written on accepted pushes only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_hp[r_wr_ptr]  <= note_half_period;
            r_fifo_dur[r_wr_ptr] <= note_dur_ms;
        end
    end

    // FIFO pointers and occupancy; a pop and a push in one cycle leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                // A skipped note chains straight into the next LOAD if more are queued.
                if (w_head_dur == '0) begin
                    w_next = (r_count > CNT_W'(1)) ? S_LOAD : S_IDLE;
                end else begin
                    w_next = S_PLAY;
                end
            end
            S_PLAY: begin
                if (w_end) begin
                    w_next = w_empty ? S_IDLE : S_LOAD;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs: pop in LOAD, note_done on skip or at the last PLAY cycle.
    always_comb begin
        w_pop  = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_pop  = 1'b1;
                w_done = (w_head_dur == '0);
            end
            S_PLAY: begin
                w_done = w_end;
            end
            default: begin
                w_pop  = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // Tone, prescaler and ms counters plus the speaker flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hp      <= '0;
            r_dur     <= '0;
            r_tone    <= '0;
            r_pre     <= '0;
            r_ms      <= '0;
            r_speaker <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_hp      <= w_head_hp;
                    r_dur     <= w_head_dur;
                    r_tone    <= '0;
                    r_pre     <= '0;
                    r_ms      <= '0;
                    r_speaker <= 1'b0;
                end
                S_PLAY: begin
                    if (w_end) begin
                        r_speaker <= 1'b0;
                    end else begin
                        if (w_tone_wrap) begin
                            r_tone    <= '0;
                            r_speaker <= ~r_speaker;
                        end else if (r_hp != '0) begin
                            r_tone <= r_tone + PERIOD_W'(1);
                        end
                        if (w_tick) begin
                            r_pre <= '0;
                            r_ms  <= r_ms + DUR_W'(1);
                        end else begin
                            r_pre <= r_pre + PRE_W'(1);
                        end
                    end
                end
                default: begin
                    r_speaker <= 1'b0;
                end
            endcase
        end
    end

    assign note_ready = !w_full;
    assign speaker    = r_speaker;
    assign busy       = (r_state != S_IDLE) || !w_empty;
    assign note_done  = w_done;

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player with TICK_DIV=10 and FIFO_DEPTH=4.
module tb_note_player;

    localparam int TICK_DIV   = 10;
    localparam int FIFO_DEPTH = 4;
    localparam int PERIOD_W   = 20;
    localparam int DUR_W      = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                note_valid = 1'b0;
    logic                note_ready;
    logic [PERIOD_W-1:0] note_half_period = '0;
    logic [DUR_W-1:0]    note_dur_ms = '0;
    logic                speaker;
    logic                busy;
    logic                note_done;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int hp;
        int dur;
        int lat;
        int tog;
    } vec_t;

    vec_t vecs [8];
    int   hpl  [4];

    always #5 clk = ~clk;

    note_player #(
        .TICK_DIV  (TICK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH),
        .PERIOD_W  (PERIOD_W),
        .DUR_W     (DUR_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .note_valid      (note_valid),
        .note_ready      (note_ready),
        .note_half_period(note_half_period),
        .note_dur_ms     (note_dur_ms),
        .speaker         (speaker),
        .busy            (busy),
        .note_done       (note_done)
    );

    task automatic check(input string name, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int hp, input int dur);
        note_valid       = 1'b1;
        note_half_period = PERIOD_W'(hp);
        note_dur_ms      = DUR_W'(dur);
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int c;
        c = 0;
        while (!note_done && c < max_cyc) begin
            step();
            c++;
        end
        check({name, " note_done seen"}, int'(note_done), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        int   lat;
        int   tog;
        int   acc;
        int   ndone;
        int   early_hi;
        int   c;
        int   run;
        int   spk12;
        int   spk13;
        int   done_at [3];
        logic prev;
        logic rdy;

        // hp, dur, cycles from push-edge count to note_done, speaker toggles up to note_done
        vecs[0] = '{hp: 3,  dur: 2, lat: 22, tog: 6};
        vecs[1] = '{hp: 1,  dur: 1, lat: 12, tog: 9};
        vecs[2] = '{hp: 0,  dur: 1, lat: 12, tog: 0};
        vecs[3] = '{hp: 2,  dur: 1, lat: 12, tog: 4};
        vecs[4] = '{hp: 5,  dur: 0, lat: 2,  tog: 0};
        vecs[5] = '{hp: 7,  dur: 3, lat: 32, tog: 4};
        vecs[6] = '{hp: 25, dur: 2, lat: 22, tog: 0};
        vecs[7] = '{hp: 4,  dur: 1, lat: 12, tog: 2};
        hpl = '{2, 3, 4, 5};

        // Reset held for 3 cycles
        rst_n = 1'b0;
        repeat (3) step();
        check("rst speaker", int'(speaker), 0);
        check("rst busy", int'(busy), 0);
        check("rst note_done", int'(note_done), 0);
        check("rst note_ready", int'(note_ready), 1);
        rst_n = 1'b1;
        step();
        check("post-rst busy", int'(busy), 0);

        // Single-note vectors
        for (int v = 0; v < 8; v++) begin
            drive(vecs[v].hp, vecs[v].dur);
            step();
            note_valid = 1'b0;
            cyc  = 1;
            lat  = -1;
            tog  = 0;
            prev = speaker;
            while (lat < 0 && cyc < 300) begin
                step();
                cyc++;
                if (speaker !== prev) tog++;
                prev = speaker;
                if (note_done) lat = cyc;
            end
            check($sformatf("vec%0d latency", v), lat, vecs[v].lat);
            check($sformatf("vec%0d toggles", v), tog, vecs[v].tog);
            step();
            check($sformatf("vec%0d speaker after", v), int'(speaker), 0);
            check($sformatf("vec%0d busy after", v), int'(busy), 0);
            check($sformatf("vec%0d done after", v), int'(note_done), 0);
        end

        // Rest, skip, then a real note
        drive(0, 1); step();
        drive(5, 0); step();
        drive(2, 1); step();
        note_valid = 1'b0;
        cyc = 3; ndone = 0; tog = 0; early_hi = 0; prev = speaker;
        done_at = '{-1, -1, -1};
        while (busy && cyc < 100) begin
            step();
            cyc++;
            if (ndone < 3 && speaker !== prev) tog++;
            prev = speaker;
            if (speaker && cyc <= 14) early_hi++;
            if (note_done) begin
                if (ndone < 3) done_at[ndone] = cyc;
                ndone++;
            end
        end
        check("rs drained in time", int'(cyc < 100), 1);
        check("rs done count", ndone, 3);
        check("rs rest done cycle", done_at[0], 12);
        check("rs skip done cycle", done_at[1], 13);
        check("rs tone done cycle", done_at[2], 24);
        check("rs rest/skip silent", early_hi, 0);
        check("rs toggles", tog, 4);

        // Back-to-back hp=1 notes
        drive(1, 1); step();
        drive(1, 1); step();
        note_valid = 1'b0;
        cyc = 2; ndone = 0; tog = 0; prev = speaker; spk12 = -1; spk13 = -1;
        done_at = '{-1, -1, -1};
        while (busy && cyc < 100) begin
            step();
            cyc++;
            if (ndone < 2 && speaker !== prev) tog++;
            prev = speaker;
            if (cyc == 12) spk12 = int'(speaker);
            if (cyc == 13) spk13 = int'(speaker);
            if (note_done) begin
                if (ndone < 3) done_at[ndone] = cyc;
                ndone++;
            end
        end
        check("b2b done count", ndone, 2);
        check("b2b first done", done_at[0], 12);
        check("b2b second done", done_at[1], 23);
        check("b2b speaker last play", spk12, 1);
        check("b2b speaker in load", spk13, 0);
        check("b2b toggles", tog, 19);

        // Full FIFO during a long note
        drive(4, 5); step();
        note_valid = 1'b0;
        repeat (4) step();
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            drive(hpl[(acc < 4) ? acc : 3], 2);
            rdy = note_ready;
            step();
            if (rdy) acc++;
        end
        note_valid = 1'b0;
        check("full accepted", acc, 4);
        check("full ready low", int'(note_ready), 0);
        wait_done("full first", 100);
        step();
        check("full ready in load", int'(note_ready), 0);
        step();
        check("full ready after pop", int'(note_ready), 1);
        for (int j = 0; j < 4; j++) begin
            c = 0;
            while (!speaker && c < 50) begin
                step();
                c++;
            end
            run = 0;
            while (speaker && run < 50) begin
                step();
                run++;
            end
            check($sformatf("full order note%0d high run", j), run, hpl[j]);
            wait_done($sformatf("full note%0d", j), 50);
            step();
        end
        check("full busy after drain", int'(busy), 0);

        // Push on the LOAD edge with 3 entries queued
        drive(1, 2); step();
        note_valid = 1'b0;
        repeat (3) step();
        drive(3, 1); step();
        drive(3, 1); step();
        drive(3, 1); step();
        note_valid = 1'b0;
        check("pp ready at 3", int'(note_ready), 1);
        wait_done("pp first", 50);
        step();
        check("pp ready in load", int'(note_ready), 1);
        drive(3, 1); step();
        note_valid = 1'b0;
        check("pp ready after push+pop", int'(note_ready), 1);
        drive(3, 1); step();
        note_valid = 1'b0;
        check("pp ready after extra push", int'(note_ready), 0);
        ndone = 0; c = 0;
        while (busy && c < 300) begin
            if (note_done) ndone++;
            step();
            c++;
        end
        check("pp notes played", ndone, 5);

        // Reset mid-PLAY with notes queued
        drive(1, 3); step();
        drive(1, 3); step();
        drive(1, 3); step();
        note_valid = 1'b0;
        c = 0;
        while (!speaker && c < 20) begin
            step();
            c++;
        end
        check("mr speaker high before reset", int'(speaker), 1);
        rst_n = 1'b0;
        #1;
        check("mr speaker in reset", int'(speaker), 0);
        check("mr busy in reset", int'(busy), 0);
        check("mr ready in reset", int'(note_ready), 1);
        check("mr done in reset", int'(note_done), 0);
        repeat (2) step();
        rst_n = 1'b1;
        ndone = 0; early_hi = 0; c = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (note_done) ndone++;
            if (speaker) early_hi++;
            if (busy) c++;
        end
        check("mr no done after reset", ndone, 0);
        check("mr no speaker after reset", early_hi, 0);
        check("mr no busy after reset", c, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
